// File: rtl/gate_selftest_ctrl.sv
// gate_selftest_ctrl: in-system self-test sequencer for a basic_gates instance.
// Drives the four A/B combinations (00, 01, 10, 11), waits SETTLE_CYCLES per
// vector, then checks the seven gate outputs against the truth table.
// Ports:
//   clk, rst       - rising-edge clock, synchronous active-high reset
//   start          - request a run (accepted only while idle)
//   gate_out[6:0]  - gate outputs {XNOR, XOR, NOR, NAND, NOTA, OR, AND}
//   a, b           - registered gate inputs
//   busy           - run in progress
//   done           - one-cycle pulse when a run completes
//   pass           - last run had no mismatches
//   fail_mask[6:0] - sticky per-gate mismatch flags of the last run
//   fail_count[4:0]- number of mismatching (vector, gate) pairs, 0..28
module gate_selftest_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] gate_out,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [4:0] fail_count
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned VEC_W  = 2;
  localparam int unsigned NGATES = 7;
  localparam int unsigned FC_W   = 5;
  localparam int unsigned PC_W   = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [VEC_W-1:0]    r_vec, w_vec_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_a, w_a_nxt;
  logic                r_b, w_b_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_pass, w_pass_nxt;
  logic [NGATES-1:0]   r_fail_mask, w_fail_mask_nxt;
  logic [FC_W-1:0]     r_fail_count, w_fail_count_nxt;

  logic [NGATES-1:0]   w_expected;
  logic [NGATES-1:0]   w_mismatch;
  logic [PC_W-1:0]     w_popcnt;
  logic [VEC_W-1:0]    w_vec_inc;

  // Truth table for the vector currently applied, and per-gate mismatches
  always_comb begin
    w_expected = {~(r_a ^ r_b), r_a ^ r_b, ~(r_a | r_b), ~(r_a & r_b),
                  ~r_a, r_a | r_b, r_a & r_b};
    w_mismatch = gate_out ^ w_expected;
    w_popcnt   = '0;
    for (int i = 0; i < int'(NGATES); i++) begin
      w_popcnt = w_popcnt + PC_W'(w_mismatch[i]);
    end
  end

  assign w_vec_inc = r_vec + VEC_W'(1);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_vec_nxt        = r_vec;
    w_cnt_nxt        = r_cnt;
    w_a_nxt          = r_a;
    w_b_nxt          = r_b;
    w_done_nxt       = 1'b0;
    w_pass_nxt       = r_pass;
    w_fail_mask_nxt  = r_fail_mask;
    w_fail_count_nxt = r_fail_count;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt      = S_SETTLE;
          w_vec_nxt        = '0;
          w_cnt_nxt        = '0;
          w_a_nxt          = 1'b0;
          w_b_nxt          = 1'b0;
          w_pass_nxt       = 1'b0;
          w_fail_mask_nxt  = '0;
          w_fail_count_nxt = '0;
        end
      end
      S_SETTLE: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_fail_mask_nxt  = r_fail_mask | w_mismatch;
        w_fail_count_nxt = r_fail_count + FC_W'(w_popcnt);
        if (r_vec != VEC_W'(3)) begin
          w_state_nxt = S_SETTLE;
          w_vec_nxt   = w_vec_inc;
          w_a_nxt     = w_vec_inc[1];
          w_b_nxt     = w_vec_inc[0];
          w_cnt_nxt   = '0;
        end else begin
          // Last vector: a/b already sit at 1/1 and hold there
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = ((r_fail_mask | w_mismatch) == '0);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_vec        <= '0;
      r_cnt        <= '0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_mask  <= '0;
      r_fail_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_vec        <= w_vec_nxt;
      r_cnt        <= w_cnt_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
      r_fail_mask  <= w_fail_mask_nxt;
      r_fail_count <= w_fail_count_nxt;
    end
  end

  assign a          = r_a;
  assign b          = r_b;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_mask  = r_fail_mask;
  assign fail_count = r_fail_count;

endmodule

// File: doc/gate_selftest_ctrl.md
# gate_selftest_ctrl

Sequencer that exhaustively exercises a `basic_gates` instance in-system. On a start request it drives the four A/B input combinations, waits a programmable settle time per vector, and samples the seven gate outputs. It compares each sample against the expected truth table and reports a per-gate fail mask, a mismatch count and a pass flag. It sits beside the `basic_gates` datapath as its only driver of A/B during self-test.

## Interface
- `SETTLE_CYCLES`, default 2: cycles between driving a vector and sampling it; legal range 1..15.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a self-test run; sampled only in IDLE.
- `gate_out`  in  7  gate outputs under test, in this bit order:
  - bit0 AND, bit1 OR, bit2 NOTA, bit3 NAND
  - bit4 NOR, bit5 XOR, bit6 XNOR
- `a`  out  1  A input to the gates (registered).
- `b`  out  1  B input to the gates (registered).
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse when a run completes.
- `pass`  out  1  last run had zero mismatches.
- `fail_mask`  out  7  sticky per-gate mismatch flags for the last run; same bit order as `gate_out`.
- `fail_count`  out  5  number of mismatching (vector, gate) pairs in the last run; range 0..28.

## Operation
- States: IDLE, SETTLE, CHECK.
- Internal registers:
  - `vec[1:0]` is the vector index; it maps to A = vec[1], B = vec[0], so vectors run in the order 00, 01, 10, 11.
  - `cnt` is the settle counter.
- IDLE with `start`=1: on that edge go to SETTLE and set the following.
  - vec=0, a=0, b=0, cnt=0.
  - `fail_mask`=0, `fail_count`=0, `pass`=0.
- SETTLE: `cnt` increments each cycle. When cnt==SETTLE_CYCLES-1, the next edge goes to CHECK.
- CHECK computes the expected vector from the current a/b:
  - {a~^b, a^b, ~(a|b), ~(a&b), ~a, a|b, a&b}
  - The mismatch vector m = gate_out ^ expected.
- CHECK register updates:
  - fail_mask |= m.
  - fail_count += popcount(m); 3-bit popcount, zero-extended, no saturation needed.
- CHECK exit, vec<3: vec++, a/b follow the new vec, cnt=0, go to SETTLE.
- CHECK exit, vec==3:
  - Go to IDLE.
  - `done`=1 for the next cycle only.
  - `pass` = (updated fail_mask == 0).
  - a/b hold 1/1.
- `start` while in SETTLE or CHECK is ignored; there is no queuing.
- Results (`pass`, `fail_mask`, `fail_count`) hold until the next accepted start, which clears them.
- `busy` = (state != IDLE).

## Timing
- Reset values: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, fail_count=0, vec=0, cnt=0.
- Per-vector cost is SETTLE_CYCLES+1 cycles.
- Latency: with `start` sampled at edge 0, `done` is high in cycle 4*(SETTLE_CYCLES+1)+1.
- Example, SETTLE_CYCLES=2: start at edge 0, then:
  - cycles 1–12: `busy` high.
  - cycles 3, 6, 9, 12: CHECK.
  - cycle 13: `done` high.
- a/b change only on the edge leaving IDLE (on start) or leaving CHECK. They are stable throughout each SETTLE and CHECK window.
- `done` and `start` in the same cycle: the controller is in IDLE, so the start is accepted. The new run begins and its clears take effect on that edge.
- `rst` mid-run: the next edge forces the reset values. No `done` pulse is issued and partial results are discarded.
- `gate_out` is sampled only in CHECK; its value in any other state is irrelevant.

## Test plan
- Fault-free gate model, SETTLE_CYCLES=2, pulse start:
  - a/b sequence 00, 01, 10, 11.
  - `done` in cycle 13 after start.
  - pass=1, fail_mask=0, fail_count=0.
- Bench forces AND output stuck-at-1:
  - Mismatches occur at vectors 00, 01, 10.
  - fail_mask=7'b0000001, fail_count=3, pass=0.
- Bench inverts all seven outputs:
  - fail_mask=7'h7F, fail_count=28, pass=0.
- `start` held high continuously:
  - Back-to-back runs; the second run starts on the `done` cycle.
  - Results are cleared at the start of the second run.
  - `start` is ignored while `busy` is high; `busy` and `done` never overlap.
- Assert `rst` during the vector-2 SETTLE:
  - Next cycle shows all reset values and no `done`.
  - A subsequent start completes a normal run.
- SETTLE_CYCLES=1 and SETTLE_CYCLES=15:
  - `done` arrives at cycle 9 and cycle 65 after start, respectively.
  - a/b stay constant across each settle window.
